// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Sequences one convolution pass for a PE-column control block:
//               load strobes, address initialise, per-row stepping with
//               adder-enable updates at row boundaries, drain and done.
//               Optional feature macro: SEQ_PERF_CNT_EN (adds perf_cycles_o,
//               a saturating count of busy cycles in the current pass).
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int N             = 3,
    parameter int NUM_COL_WIDTH = $clog2(N),
    parameter int SEL_WIDTH     = $clog2(N),
    parameter int ROW_WIDTH     = 8,
    parameter int DRAIN_CYCLES  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    output logic                     ready_o,
    input  logic [NUM_COL_WIDTH-1:0] cfg_column_num_i,
    input  logic [SEL_WIDTH-1:0]     cfg_f_sel_i,
    input  logic [ROW_WIDTH-1:0]     cfg_num_rows_i,
    input  logic                     abort_i,
    output logic                     column_num_ld_o,
    output logic [NUM_COL_WIDTH-1:0] column_num_o,
    output logic                     f_sel_ld_o,
    output logic [SEL_WIDTH-1:0]     f_sel_o,
    output logic                     mreg_addrs_rst_o,
    output logic                     mreg_start_o,
    output logic                     en_adder_ld_o,
    output logic                     en_adder_1_o,
    output logic                     en_adder_2_o,
    output logic                     done_o,
    output logic                     busy_o
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]              perf_cycles_o
`endif
);

    localparam int STEP_W  = (N > 1) ? $clog2(N) : 1;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [STEP_W-1:0]  C_STEP_LAST  = STEP_W'(N - 1);
    localparam logic [DRAIN_W-1:0] C_DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_INIT  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [STEP_W-1:0]      r_step;
    logic [ROW_WIDTH-1:0]   r_row;
    logic [ROW_WIDTH-1:0]   r_rows;
    logic [DRAIN_W-1:0]     r_drain;
    logic [NUM_COL_WIDTH-1:0] r_col;
    logic [SEL_WIDTH-1:0]   r_fsel;

    logic                   w_accept;
    logic                   w_step_last;
    logic                   w_row_last;
    logic                   w_drain_last;
    logic                   w_col_full;
    logic [ROW_WIDTH-1:0]   w_rows_last;

    // A zero row count runs as a single row.
    assign w_rows_last  = (r_rows == '0) ? '0 : (r_rows - 1'b1);
    assign w_step_last  = (r_step == C_STEP_LAST);
    assign w_row_last   = (r_row == w_rows_last);
    assign w_drain_last = (r_drain == C_DRAIN_LAST);
    assign w_col_full   = (32'(r_col) == N);
    assign w_accept     = (r_state == S_IDLE) && start_i && !abort_i;

    assign column_num_o = r_col;
    assign f_sel_o      = r_fsel;
    assign ready_o      = (r_state == S_IDLE);
    assign busy_o       = ~ready_o;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle strobes; abort overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        column_num_ld_o  = 1'b0;
        f_sel_ld_o       = 1'b0;
        mreg_addrs_rst_o = 1'b0;
        mreg_start_o     = 1'b0;
        en_adder_ld_o    = 1'b0;
        en_adder_1_o     = 1'b0;
        en_adder_2_o     = 1'b0;
        done_o           = 1'b0;
        if (abort_i) begin
            w_state_nxt   = S_IDLE;
            en_adder_ld_o = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) w_state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    column_num_ld_o = 1'b1;
                    f_sel_ld_o      = 1'b1;
                    en_adder_ld_o   = 1'b1;
                    w_state_nxt     = S_INIT;
                end
                S_INIT: begin
                    mreg_addrs_rst_o = 1'b1;
                    w_state_nxt      = S_RUN;
                end
                S_RUN: begin
                    mreg_start_o = 1'b1;
                    if (w_step_last) begin
                        en_adder_ld_o = 1'b1;
                        en_adder_1_o  = 1'b1;
                        en_adder_2_o  = w_col_full;
                        if (w_row_last) w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_last) begin
                        en_adder_ld_o = 1'b1;
                        w_state_nxt   = S_DONE;
                    end
                end
                S_DONE: begin
                    done_o      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Step, row and drain counters; cleared on abort, in IDLE and in INIT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_step  <= '0;
            r_row   <= '0;
            r_drain <= '0;
        end else if (abort_i) begin
            r_step  <= '0;
            r_row   <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_step_last) begin
                        r_step <= '0;
                        r_row  <= r_row + 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_DRAIN: r_drain <= r_drain + 1'b1;
                default: begin
                    r_step  <= '0;
                    r_row   <= '0;
                    r_drain <= '0;
                end
            endcase
        end
    end

    // Pass configuration captured only on an accepted start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_col  <= '0;
            r_fsel <= '0;
            r_rows <= '0;
        end else if (w_accept) begin
            r_col  <= cfg_column_num_i;
            r_fsel <= cfg_f_sel_i;
            r_rows <= cfg_num_rows_i;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_perf;
    assign perf_cycles_o = r_perf;

    // Busy-cycle counter: restarts on accept, saturates, holds once idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (busy_o && (r_perf != '1)) begin
            r_perf <= r_perf + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. A pass is modelled
//               as a cycle index since accept; expected strobes follow from
//               that index with plain arithmetic. Optional macro:
//               SEQ_PERF_CNT_EN (also checks perf_cycles_o).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int N  = 3;
    localparam int D  = 2;
    localparam int CW = $clog2(N);
    localparam int SW = $clog2(N);
    localparam int RW = 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [CW-1:0] cfg_column_num_i = '0;
    logic [SW-1:0] cfg_f_sel_i = '0;
    logic [RW-1:0] cfg_num_rows_i = '0;
    logic          ready_o, column_num_ld_o, f_sel_ld_o, mreg_addrs_rst_o;
    logic          mreg_start_o, en_adder_ld_o, en_adder_1_o, en_adder_2_o;
    logic          done_o, busy_o;
    logic [CW-1:0] column_num_o;
    logic [SW-1:0] f_sel_o;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]   perf_cycles_o;
`endif

    int total = 0;
    int bad   = 0;

    // Model: m_k = cycles since accept (0 = idle)
    int            m_k    = 0;
    int            m_col  = 0;
    int            m_fsel = 0;
    int            m_rows = 0;
    int            m_perf = 0;
    logic          obs_done = 1'b0;

    control_sequencer #(
        .N(N), .NUM_COL_WIDTH(CW), .SEL_WIDTH(SW), .ROW_WIDTH(RW), .DRAIN_CYCLES(D)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .start_i          (start_i),
        .ready_o          (ready_o),
        .cfg_column_num_i (cfg_column_num_i),
        .cfg_f_sel_i      (cfg_f_sel_i),
        .cfg_num_rows_i   (cfg_num_rows_i),
        .abort_i          (abort_i),
        .column_num_ld_o  (column_num_ld_o),
        .column_num_o     (column_num_o),
        .f_sel_ld_o       (f_sel_ld_o),
        .f_sel_o          (f_sel_o),
        .mreg_addrs_rst_o (mreg_addrs_rst_o),
        .mreg_start_o     (mreg_start_o),
        .en_adder_ld_o    (en_adder_ld_o),
        .en_adder_1_o     (en_adder_1_o),
        .en_adder_2_o     (en_adder_2_o),
        .done_o           (done_o),
        .busy_o           (busy_o)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles_o    (perf_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pass_len(input int rows);
        int r;
        r = (rows == 0) ? 1 : rows;
        return 2 + N * r + D + 1;
    endfunction

    // Expected {ready,busy,col_ld,fsel_ld,addrs_rst,mstart,en_ld,e1,e2,done}
    function automatic logic [9:0] exp_strobes(input int k, input logic ab, input int col, input int rows);
        logic [9:0] v;
        int run_end, len, r;
        v = '0;
        v[9] = (k == 0);
        v[8] = (k != 0);
        len = pass_len(rows);
        run_end = len - D - 1;
        if (ab) begin
            v[3] = 1'b1;
        end else if (k == 1) begin
            v[7] = 1'b1; v[6] = 1'b1; v[3] = 1'b1;
        end else if (k == 2) begin
            v[5] = 1'b1;
        end else if (k >= 3 && k <= run_end) begin
            v[4] = 1'b1;
            r = k - 2;
            if (r % N == 0) begin
                v[3] = 1'b1; v[2] = 1'b1; v[1] = (col == N);
            end
        end else if (k > run_end && k < len) begin
            if (k == run_end + D) v[3] = 1'b1;
        end else if (k == len) begin
            v[0] = 1'b1;
        end
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        logic [9:0] obs;
        obs = {ready_o, busy_o, column_num_ld_o, f_sel_ld_o, mreg_addrs_rst_o,
               mreg_start_o, en_adder_ld_o, en_adder_1_o, en_adder_2_o, done_o};
        obs_done = done_o;
        chk({tag, "/strobes"}, 32'(obs), 32'(exp_strobes(m_k, abort_i, m_col, m_rows)));
        chk({tag, "/col"}, 32'(column_num_o), 32'(m_col));
        chk({tag, "/fsel"}, 32'(f_sel_o), 32'(m_fsel));
`ifdef SEQ_PERF_CNT_EN
        chk({tag, "/perf"}, perf_cycles_o, 32'(m_perf));
`endif
    endtask

    task automatic model_reset();
        m_k = 0; m_col = 0; m_fsel = 0; m_rows = 0; m_perf = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        if (!rst_n_i) begin
            model_reset();
        end else begin
            if (m_k != 0 && m_perf != 32'hFFFF_FFFF) m_perf++;
            if (abort_i) begin
                m_k = 0;
            end else if (m_k == 0) begin
                if (start_i) begin
                    m_k = 1; m_perf = 0;
                    m_col = int'(cfg_column_num_i);
                    m_fsel = int'(cfg_f_sel_i);
                    m_rows = int'(cfg_num_rows_i);
                end
            end else if (m_k == pass_len(m_rows)) begin
                m_k = 0;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clk_i);
        check_outputs(tag);
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic set_cfg(input int col, input int fsel, input int rows);
        cfg_column_num_i = CW'(col);
        cfg_f_sel_i      = SW'(fsel);
        cfg_num_rows_i   = RW'(rows);
    endtask

    // Issue a single start, then count cycles until done_o (bounded).
    task automatic pass_latency(input string tag, input int col, input int rows, input int exp_lat);
        int lat;
        set_cfg(col, 1, rows);
        start_i = 1'b1;
        tick({tag, "/acc"});
        start_i = 1'b0;
        set_cfg(0, 0, 0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(tag);
            if (obs_done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        // Reset state
        tick("reset");
        tick("reset");
        rst_n_i = 1'b1;
        tick("idle");

        // col=2, f_sel=1, rows=2: done on cycle 2+6+2+1
        pass_latency("c2r2", 2, 2, 2 + N * 2 + D + 1);
`ifdef SEQ_PERF_CNT_EN
        tick("perf_hold");
        chk("perf_c2r2", perf_cycles_o, 32'd11);
`endif
        // Full column, single row
        pass_latency("c3r1", 3, 1, 2 + N * 1 + D + 1);
        // rows=0 behaves as rows=1
        pass_latency("c1r0", 1, 0, 2 + N * 1 + D + 1);

        // Abort on RUN cycle 2, then restart on the following cycle
        set_cfg(2, 0, 3);
        start_i = 1'b1;
        tick("ab_acc");
        start_i = 1'b0;
        tick("ab_load");
        tick("ab_init");
        tick("ab_run1");
        abort_i = 1'b1;
        tick("ab_run2");
        abort_i = 1'b0;
        chk("ab_idle", 32'(ready_o), 32'd1);
        start_i = 1'b1;
        set_cfg(3, 2, 1);
        tick("ab_restart");
        start_i = 1'b0;
        chk("ab_restart_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 12; i++) tick("ab_pass");

        // Abort together with start in IDLE: no accept
        start_i = 1'b1; abort_i = 1'b1; set_cfg(1, 3, 4);
        tick("ab_start_idle");
        start_i = 1'b0; abort_i = 1'b0;
        tick("ab_start_idle2");

        // Start held high through two back-to-back passes
        start_i = 1'b1; set_cfg(2, 1, 1);
        for (int i = 0; i < 2 * pass_len(1) + 3; i++) tick("held");
        start_i = 1'b0;
        for (int i = 0; i < pass_len(1) + 2; i++) tick("held_tail");

        // Asynchronous reset mid-pass
        start_i = 1'b1; set_cfg(3, 3, 4);
        tick("rst_acc");
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) tick("rst_run");
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        tick("rst_hold");
        rst_n_i = 1'b1;
        tick("rst_idle");

        // Randomised traffic: cfg changes every cycle, sparse aborts
        for (int i = 0; i < 800; i++) begin
            start_i = ($urandom_range(0, 3) == 0);
            abort_i = ($urandom_range(0, 39) == 0);
            set_cfg($urandom_range(1, N), $urandom_range(0, 3), $urandom_range(0, 5));
            tick("rand");
        end
        start_i = 1'b0; abort_i = 1'b0;
        for (int i = 0; i < 25; i++) tick("rand_tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
